// File: rtl/lcd8080_pattern_engine_pkg.sv
// Shared constants for the i8080 test-pattern engine: register decode, pattern modes,
// colour-bar table and RGB565 helpers.
package lcd8080_pkg;

    localparam logic [2:0] A_RES  = 3'd0;
    localparam logic [2:0] A_CTRL = 3'd1;
    localparam logic [2:0] A_PIX  = 3'd2;
    localparam logic [2:0] A_BL   = 3'd3;
    localparam logic [2:0] A_TEST = 3'd4;

    localparam logic [4:0] CTRL_RST = 5'h00;
    localparam logic [4:0] PIX_RST  = 5'h00;
    localparam logic       BL_RST   = 1'b1;
    localparam logic [4:0] TEST_RST = 5'h00;

    typedef enum logic [1:0] {
        M_BARS  = 2'd0,
        M_SOLID = 2'd1,
        M_CHECK = 2'd2,
        M_RAMP  = 2'd3
    } mode_e;

    // black, blue, green, red, white, cyan, magenta, yellow
    localparam logic [15:0] BAR_LUT [0:7] = '{
        16'h0000, 16'h001F, 16'h07E0, 16'hF800,
        16'hFFFF, 16'h07FF, 16'hF81F, 16'hFFE0
    };

    // Same 5-bit level on R, G and B; G gets its sixth bit from the level MSB.
    function automatic logic [15:0] rgb565_grey(input logic [4:0] lvl);
        return {lvl, lvl, lvl[4], lvl};
    endfunction

    function automatic logic [23:0] rgb565_to_888(input logic [15:0] c);
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
        r = c[15:11];
        g = c[10:5];
        b = c[4:0];
        return {r, r[4:2], g, g[5:4], b, b[4:2]};
    endfunction

endpackage

// File: rtl/lcd8080_pattern_engine_if.sv
// i8080 MCU port plus the byte stream toward the line FIFO.
interface lcd8080_pattern_engine_if;
    logic       J80_RS;
    logic       J80_We;
    logic       J80_Re;
    logic [7:0] J80_Din;
    logic [7:0] J80_Dout;
    logic       J80_Doe;
    logic       FIFO_Full;
    logic       FIFOWe;
    logic [7:0] RGBData;

    modport master (
        output J80_RS, J80_We, J80_Re, J80_Din, FIFO_Full,
        input  J80_Dout, J80_Doe, FIFOWe, RGBData
    );

    modport slave (
        input  J80_RS, J80_We, J80_Re, J80_Din, FIFO_Full,
        output J80_Dout, J80_Doe, FIFOWe, RGBData
    );
endinterface

// File: rtl/lcd8080_pattern_engine_reg_if.sv
// i8080 register port: synchronises the async strobe/data, commits one write per strobe,
// holds CTRL/PIX/BL/TEST and drives the registered readback.
module lcd8080_reg_if
    import lcd8080_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       J80_RS,
    input  logic       J80_We,
    input  logic       J80_Re,
    input  logic [7:0] J80_Din,
    input  logic       FIFO_Full,
    input  logic [3:0] line_cnt,
    output logic [4:0] ctrl,
    output logic [4:0] pix,
    output logic       bl_en,
    output logic [4:0] test,
    output logic [7:0] J80_Dout,
    output logic       J80_Doe
);

    logic [2:0] we_s;
    logic [1:0] rs_s;
    logic [7:0] din_s1;
    logic [7:0] din_s2;
    logic       wr_commit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            we_s   <= '0;
            rs_s   <= '0;
            din_s1 <= '0;
            din_s2 <= '0;
        end else begin
            we_s   <= {we_s[1:0], J80_We};
            rs_s   <= {rs_s[0], J80_RS};
            din_s1 <= J80_Din;
            din_s2 <= din_s1;
        end
    end

    // we_s[1] is the synchronised strobe, we_s[2] its previous value
    assign wr_commit = we_s[1] & ~we_s[2] & rs_s[1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ctrl  <= CTRL_RST;
            pix   <= PIX_RST;
            bl_en <= BL_RST;
            test  <= TEST_RST;
        end else if (wr_commit) begin
            case (din_s2[7:5])
                A_RES: begin
                    ctrl  <= CTRL_RST;
                    pix   <= PIX_RST;
                    bl_en <= BL_RST;
                    test  <= TEST_RST;
                end
                A_CTRL:  ctrl  <= din_s2[4:0];
                A_PIX:   pix   <= din_s2[4:0];
                A_BL:    bl_en <= din_s2[0];
                A_TEST:  test  <= din_s2[4:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            J80_Dout <= '0;
        end else if (rs_s[1]) begin
            J80_Dout <= {3'b001, ctrl};
        end else begin
            J80_Dout <= {ctrl[2], ctrl[1:0], FIFO_Full, line_cnt};
        end
    end

    assign J80_Doe = J80_Re & ~J80_We;

endmodule

// File: rtl/lcd8080_pattern_engine.sv
// Test-pattern source: one line of pattern bytes per HSYNC into the downstream line FIFO.
//   state    | meaning
//   S_IDLE   | blanking or disabled, counters cleared
//   S_ACTIVE | emitting one byte per cycle unless FIFO_Full
//   S_DONE   | line complete, waiting for HSYNC
module lcd8080_pattern_engine
    import lcd8080_pkg::*;
#(
    parameter int H_ACTIVE  = 800,
    parameter int BPP_BYTES = 2,
    parameter int N_BARS    = 4,
    parameter int CHK_SHIFT = 4,
    parameter int CNT_W     = 16
)(
    input  logic CLK,
    input  logic RST,
    input  logic HSYNC,
    input  logic VSYNC,
    lcd8080_pattern_engine_if.slave bus,
    output logic LCD_BL
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [CNT_W-1:0] PIX_LAST   = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] BAR_RELOAD = CNT_W'(H_ACTIVE / N_BARS - 1);
    localparam logic [1:0]       LANE_LAST  = 2'(BPP_BYTES - 1);

    logic [4:0]       ctrl;
    logic [4:0]       pix;
    logic [4:0]       test;
    logic             bl_en;
    logic [1:0]       state;
    logic [CNT_W-1:0] pix_cnt;
    logic [1:0]       lane_cnt;
    logic [CNT_W-1:0] bar_left;
    logic [2:0]       bar_idx;
    logic [CNT_W-1:0] line_cnt;
    logic             hsync_d;
    mode_e            mode_q;
    logic [4:0]       pix_q;
    logic [15:0]      color;
    logic [23:0]      rgb888;
    logic [7:0]       byte_val;
    logic             fifo_we_q;
    logic [7:0]       rgb_q;

    lcd8080_reg_if u_reg_if (
        .CLK       (CLK),
        .RST       (RST),
        .J80_RS    (bus.J80_RS),
        .J80_We    (bus.J80_We),
        .J80_Re    (bus.J80_Re),
        .J80_Din   (bus.J80_Din),
        .FIFO_Full (bus.FIFO_Full),
        .line_cnt  (line_cnt[3:0]),
        .ctrl      (ctrl),
        .pix       (pix),
        .bl_en     (bl_en),
        .test      (test),
        .J80_Dout  (bus.J80_Dout),
        .J80_Doe   (bus.J80_Doe)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hsync_d  <= 1'b0;
            line_cnt <= '0;
            LCD_BL   <= BL_RST;
        end else begin
            hsync_d <= HSYNC;
            LCD_BL  <= bl_en;
            if (VSYNC) begin
                line_cnt <= '0;
            end else if (HSYNC && !hsync_d && line_cnt != '1) begin
                line_cnt <= line_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        color = 16'h0000;
        case (mode_q)
            M_BARS:  color = BAR_LUT[bar_idx];
            M_SOLID: color = rgb565_grey(pix_q);
            M_CHECK: color = (pix_cnt[CHK_SHIFT] ^ line_cnt[CHK_SHIFT]) ? 16'hFFFF : 16'h0000;
            M_RAMP:  color = rgb565_grey(pix_cnt[9:5]);
            default: color = 16'h0000;
        endcase

        rgb888   = rgb565_to_888(color);
        byte_val = color[15:8];
        if (BPP_BYTES == 2 && lane_cnt == 2'd1) begin
            byte_val = color[7:0];
        end
        if (BPP_BYTES == 3) begin
            case (lane_cnt)
                2'd0:    byte_val = rgb888[23:16];
                2'd1:    byte_val = rgb888[15:8];
                default: byte_val = rgb888[7:0];
            endcase
        end
        if (test[0]) begin
            byte_val = {test[4:1], test[4:1]};
        end
    end

    // Mode and PIX are captured at line start so register writes land on the next line.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            pix_cnt   <= '0;
            lane_cnt  <= '0;
            bar_left  <= BAR_RELOAD;
            bar_idx   <= '0;
            mode_q    <= M_BARS;
            pix_q     <= '0;
            fifo_we_q <= 1'b0;
            rgb_q     <= '0;
        end else begin
            fifo_we_q <= 1'b0;
            if (HSYNC || VSYNC) begin
                state    <= S_IDLE;
                pix_cnt  <= '0;
                lane_cnt <= '0;
                bar_left <= BAR_RELOAD;
                bar_idx  <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        pix_cnt  <= '0;
                        lane_cnt <= '0;
                        bar_left <= BAR_RELOAD;
                        bar_idx  <= '0;
                        if (ctrl[2]) begin
                            state  <= S_ACTIVE;
                            mode_q <= mode_e'(ctrl[1:0]);
                            pix_q  <= pix;
                        end
                    end
                    S_ACTIVE: begin
                        if (!bus.FIFO_Full) begin
                            fifo_we_q <= 1'b1;
                            rgb_q     <= byte_val;
                            if (lane_cnt == LANE_LAST) begin
                                lane_cnt <= '0;
                                pix_cnt  <= pix_cnt + 1'b1;
                                if (bar_left == '0) begin
                                    bar_left <= BAR_RELOAD;
                                    bar_idx  <= bar_idx + 1'b1;
                                end else begin
                                    bar_left <= bar_left - 1'b1;
                                end
                                if (pix_cnt == PIX_LAST) begin
                                    state <= S_DONE;
                                end
                            end else begin
                                lane_cnt <= lane_cnt + 1'b1;
                            end
                        end
                    end
                    S_DONE:  ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.FIFOWe  = fifo_we_q;
    assign bus.RGBData = rgb_q;

endmodule

// File: tb/tb_lcd8080_pattern_engine.sv
// Directed bench for lcd8080_pattern_engine: a per-cycle behavioural model plus literal spot checks.
module tb_lcd8080_pattern_engine;

    localparam int H_ACTIVE  = 800;
    localparam int BPP       = 2;
    localparam int N_BARS    = 4;
    localparam int CHK_SHIFT = 4;
    localparam int LINE_MAX  = 65535;
    localparam int LINE_BYTES = H_ACTIVE * BPP;

    logic CLK = 1'b0;
    logic RST;
    logic HSYNC;
    logic VSYNC;
    logic LCD_BL;

    lcd8080_pattern_engine_if bus ();

    lcd8080_pattern_engine dut (
        .CLK    (CLK),
        .RST    (RST),
        .HSYNC  (HSYNC),
        .VSYNC  (VSYNC),
        .bus    (bus),
        .LCD_BL (LCD_BL)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int lut [8] = '{0, 31, 2016, 63488, 65535, 2047, 63519, 65504};

    function automatic int rgb_of_level(input int lvl);
        return lvl * 2048 + (lvl * 2 + lvl / 16) * 32 + lvl;
    endfunction

    function automatic int model_byte(input int mode, input int pixv, input int testv,
                                      input int line, input int pos);
        int px;
        int lane;
        int c;
        if (testv % 2 == 1) return (testv / 2) * 17;
        px   = pos / BPP;
        lane = pos % BPP;
        case (mode)
            0: c = lut[px * N_BARS / H_ACTIVE];
            1: c = rgb_of_level(pixv);
            2: c = (((px >> CHK_SHIFT) % 2) != ((line >> CHK_SHIFT) % 2)) ? 65535 : 0;
            default: c = rgb_of_level((px / 32) % 32);
        endcase
        return (lane == 0) ? c / 256 : c % 256;
    endfunction

    int m_ctrl, m_pix, m_bl, m_test, m_line, hs_prev;
    int running, finished, pos, lmode, lpix;
    int we_h [3];
    int rs_h [3];
    int din_h [3];
    int e_we, e_data, e_bl, e_dout, e_doe, e_chk_data;

    int cap [2048];
    int cap_n = 0;

    always @(posedge CLK) begin
        if (RST) begin
            m_ctrl = 0; m_pix = 0; m_bl = 1; m_test = 0; m_line = 0; hs_prev = 0;
            running = 0; finished = 0; pos = 0; lmode = 0; lpix = 0;
            for (int i = 0; i < 3; i++) begin we_h[i] = 0; rs_h[i] = 0; din_h[i] = 0; end
            e_we = 0; e_data = 0; e_bl = 1; e_dout = 0; e_chk_data = 1;
        end else begin
            e_bl = m_bl;
            if (rs_h[1] == 1)
                e_dout = 32 + m_ctrl;
            else
                e_dout = ((m_ctrl / 4) % 2) * 128 + (m_ctrl % 4) * 32
                         + int'(bus.FIFO_Full) * 16 + m_line % 16;
            e_we = 0;
            e_chk_data = 0;
            if (HSYNC || VSYNC) begin
                running = 0; finished = 0; pos = 0;
            end else if (running == 1) begin
                if (!bus.FIFO_Full) begin
                    e_we = 1;
                    e_chk_data = 1;
                    e_data = model_byte(lmode, lpix, m_test, m_line, pos);
                    pos++;
                    if (pos == LINE_BYTES) begin running = 0; finished = 1; end
                end
            end else if (finished == 0 && (m_ctrl / 4) % 2 == 1) begin
                running = 1; pos = 0; lmode = m_ctrl % 4; lpix = m_pix;
            end
            if (VSYNC) m_line = 0;
            else if (HSYNC && hs_prev == 0 && m_line < LINE_MAX) m_line++;
            hs_prev = int'(HSYNC);
            if (we_h[1] == 1 && we_h[2] == 0 && rs_h[1] == 1) begin
                case (din_h[1] / 32)
                    0: begin m_ctrl = 0; m_pix = 0; m_bl = 1; m_test = 0; end
                    1: m_ctrl = din_h[1] % 32;
                    2: m_pix  = din_h[1] % 32;
                    3: m_bl   = din_h[1] % 2;
                    4: m_test = din_h[1] % 32;
                    default: ;
                endcase
            end
            we_h[2] = we_h[1];  we_h[1] = we_h[0];  we_h[0] = int'(bus.J80_We);
            rs_h[2] = rs_h[1];  rs_h[1] = rs_h[0];  rs_h[0] = int'(bus.J80_RS);
            din_h[2] = din_h[1]; din_h[1] = din_h[0]; din_h[0] = int'(bus.J80_Din);
        end
        e_doe = (bus.J80_Re && !bus.J80_We) ? 1 : 0;
        #1;
        chk("fifowe", int'(bus.FIFOWe), e_we);
        if (e_chk_data == 1) chk("rgbdata", int'(bus.RGBData), e_data);
        chk("lcd_bl", int'(LCD_BL), e_bl);
        chk("dout", int'(bus.J80_Dout), e_dout);
        chk("doe", int'(bus.J80_Doe), e_doe);
        if (bus.FIFOWe === 1'b1 && cap_n < 2048) begin
            cap[cap_n] = int'(bus.RGBData);
            cap_n++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic j80_write(input logic [7:0] d);
        @(negedge CLK);
        bus.J80_RS  = 1'b1;
        bus.J80_Din = d;
        bus.J80_We  = 1'b1;
        tick(2);
        bus.J80_We  = 1'b0;
        tick(3);
    endtask

    task automatic wait_cap(input int n, input int budget);
        int k;
        k = 0;
        while (cap_n < n && k < budget) begin
            @(negedge CLK);
            k++;
        end
        chk("wait_bytes", (cap_n >= n) ? 1 : 0, 1);
    endtask

    task automatic start_line();
        @(negedge CLK);
        HSYNC = 1'b1;
        tick(2);
        HSYNC = 1'b0;
        cap_n = 0;
    endtask

    initial begin
        RST = 1'b1;
        HSYNC = 1'b1;
        VSYNC = 1'b1;
        bus.J80_RS = 1'b0;
        bus.J80_We = 1'b0;
        bus.J80_Re = 1'b0;
        bus.J80_Din = 8'h00;
        bus.FIFO_Full = 1'b0;
        tick(3);
        chk("rst_fifowe", int'(bus.FIFOWe), 0);
        chk("rst_rgb", int'(bus.RGBData), 0);
        chk("rst_bl", int'(LCD_BL), 1);
        chk("rst_dout", int'(bus.J80_Dout), 0);
        RST = 1'b0;
        tick(2);

        // 1: colour bars, full line
        j80_write(8'h24);
        VSYNC = 1'b0;
        tick(2);
        start_line();
        wait_cap(LINE_BYTES, 2000);
        tick(5);
        chk("t1_len", cap_n, 1600);
        chk("t1_b0", cap[0], 8'h00);
        chk("t1_b1", cap[1], 8'h00);
        chk("t1_b400", cap[400], 8'h00);
        chk("t1_b401", cap[401], 8'h1F);
        chk("t1_b800", cap[800], 8'h07);
        chk("t1_b801", cap[801], 8'hE0);
        chk("t1_b1200", cap[1200], 8'hF8);
        chk("t1_done_we", int'(bus.FIFOWe), 0);

        // 2: backpressure for 10 cycles around byte 500
        start_line();
        wait_cap(500, 700);
        bus.FIFO_Full = 1'b1;
        tick(10);
        bus.FIFO_Full = 1'b0;
        wait_cap(LINE_BYTES, 2000);
        tick(5);
        chk("t2_len", cap_n, 1600);
        chk("t2_b801", cap[801], 8'hE0);
        chk("t2_b1599", cap[1599], 8'h00);

        // 3: HSYNC abort mid-line
        start_line();
        wait_cap(300, 400);
        HSYNC = 1'b1;
        @(posedge CLK);
        #1 chk("t3_abort_we", int'(bus.FIFOWe), 0);
        @(negedge CLK);
        HSYNC = 1'b0;
        cap_n = 0;
        wait_cap(LINE_BYTES, 2000);
        tick(5);
        chk("t3_len", cap_n, 1600);
        chk("t3_b0", cap[0], 8'h00);
        chk("t3_b401", cap[401], 8'h1F);

        // 4: register writes mid-line affect the next line only
        start_line();
        wait_cap(100, 200);
        j80_write(8'h5A);
        j80_write(8'h25);
        wait_cap(LINE_BYTES, 2000);
        tick(5);
        chk("t4_cur_b401", cap[401], 8'h1F);
        chk("t4_cur_b800", cap[800], 8'h07);
        start_line();
        wait_cap(LINE_BYTES, 2000);
        tick(5);
        chk("t4_next_b0", cap[0], 8'hD6);
        chk("t4_next_b1", cap[1], 8'hBA);
        chk("t4_next_b1599", cap[1599], 8'hBA);

        // 5: backlight, soft reset, readback
        @(negedge CLK);
        HSYNC = 1'b1;
        bus.J80_RS  = 1'b1;
        bus.J80_Din = 8'h60;
        bus.J80_We  = 1'b1;
        repeat (3) @(posedge CLK);
        #1 chk("t5_bl_hold", int'(LCD_BL), 1);
        @(posedge CLK);
        #1 chk("t5_bl_off", int'(LCD_BL), 0);
        @(negedge CLK);
        bus.J80_We = 1'b0;
        tick(4);
        j80_write(8'h00);
        tick(2);
        chk("t5_bl_on", int'(LCD_BL), 1);
        @(negedge CLK);
        bus.J80_RS = 1'b1;
        bus.J80_Re = 1'b1;
        tick(3);
        chk("t5_dout", int'(bus.J80_Dout), 8'h20);
        chk("t5_doe", int'(bus.J80_Doe), 1);
        bus.J80_Re = 1'b0;

        // 6: checkerboard on lines 0 and 16, then reset mid-line
        j80_write(8'h26);
        VSYNC = 1'b1;
        tick(2);
        VSYNC = 1'b0;
        tick(2);
        HSYNC = 1'b0;
        cap_n = 0;
        wait_cap(40, 100);
        chk("t6_l0_p0", cap[0], 8'h00);
        chk("t6_l0_p16h", cap[32], 8'hFF);
        chk("t6_l0_p16l", cap[33], 8'hFF);
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            HSYNC = 1'b1;
            tick(2);
            HSYNC = 1'b0;
            tick(2);
        end
        start_line();
        wait_cap(60, 100);
        chk("t6_l16_p0", cap[0], 8'hFF);
        chk("t6_l16_p16h", cap[32], 8'h00);
        chk("t6_l16_p16l", cap[33], 8'h00);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("t6_rst_we", int'(bus.FIFOWe), 0);
        chk("t6_rst_rgb", int'(bus.RGBData), 0);
        chk("t6_rst_bl", int'(LCD_BL), 1);
        chk("t6_rst_dout", int'(bus.J80_Dout), 0);
        tick(2);
        RST = 1'b0;
        tick(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
